sha_digest_tx: RTL and testbench

SHA_DIGEST_TX -- requirements
Module: sha_digest_tx

---
 rtl/sha_digest_tx.sv | 95 +++++++++
 tb/tb_sha_digest_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sha_digest_tx.sv
// SHA-3 digest streamer: captures the leading 512 bits of a Keccak state
// and emits the selected digest as a 16-bit stream, two bytes per word.
module sha_digest_tx #(
  parameter int WORD_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [1599:0]     state_in,
  input  logic              state_valid,
  input  logic [1:0]        ID,
  output logic              state_ready,
  output logic [WORD_W-1:0] TDATA,
  output logic              TVALID,
  input  logic              TREADY,
  output logic              TLAST,
  output logic [1:0]        TID
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [511:0] cap_q;
  logic [1:0]   id_q;
  logic [4:0]   cnt_q;
  logic [4:0]   last_idx;
  logic [63:0]  lane;
  logic [15:0]  chunk;
  logic         capture;
  logic         xfer;
  logic         unused_upper;

  // Lanes beyond (2,1) never reach the stream, even for SHA3-512.
  assign unused_upper = ^state_in[1599:512];

  assign capture = (state_q == IDLE) && state_valid;
  assign xfer    = (state_q == SEND) && TREADY;

  always_comb begin
    last_idx = 5'd31;
    unique case (id_q)
      2'd0: last_idx = 5'd13;
      2'd1: last_idx = 5'd15;
      2'd2: last_idx = 5'd23;
      2'd3: last_idx = 5'd31;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      cap_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cap_q <= state_in[511:0];
        id_q  <= ID;
        cnt_q <= '0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    state_ready = 1'b0;
    TVALID      = 1'b0;
    TLAST       = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_ready = 1'b1;
        if (state_valid) state_d = SEND;
      end
      SEND: begin
        TVALID = 1'b1;
        TLAST  = (cnt_q == last_idx);
        if (TREADY && TLAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte 2k goes to the high half so the stream reads in digest order.
  assign lane  = cap_q[{cnt_q[4:2], 6'd0} +: 64];
  assign chunk = lane[{cnt_q[1:0], 4'd0} +: 16];
  assign TDATA = TVALID ? {chunk[7:0], chunk[15:8]} : '0;
  assign TID   = id_q;

endmodule

// File: tb/tb_sha_digest_tx.sv
// Bench for sha_digest_tx: directed SHA-3 vectors plus random packets,
// checked against a byte-stream model of the digest.
module tb_sha_digest_tx;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [1599:0] state_in = '0;
  logic          state_valid = 1'b0;
  logic [1:0]    ID = 2'd0;
  logic          state_ready;
  logic [15:0]   TDATA;
  logic          TVALID;
  logic          TREADY = 1'b0;
  logic          TLAST;
  logic [1:0]    TID;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [511:0] D224 =
    {224'h6b4e03423667dbb73b6e15454f0eb1abd4597f9a1b078e3f5b5a6bc7, 288'h0};
  localparam logic [511:0] D256 =
    {256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a,
     256'h0};
  localparam logic [511:0] D512 =
    512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;

  sha_digest_tx #(.WORD_W(16)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .state_in    (state_in),
    .state_valid (state_valid),
    .ID          (ID),
    .state_ready (state_ready),
    .TDATA       (TDATA),
    .TVALID      (TVALID),
    .TREADY      (TREADY),
    .TLAST       (TLAST),
    .TID         (TID)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Digest length in bits divided into 16-bit words.
  function automatic int plen(input int id);
    int bits[4] = '{224, 256, 384, 512};
    return bits[id] / 16;
  endfunction

  // Byte j of the digest is byte j of the little-endian state.
  function automatic logic [15:0] exp_word(input logic [1599:0] st,
                                           input int k);
    logic [7:0] a;
    logic [7:0] b;
    a = st[16*k +: 8];
    b = st[16*k+8 +: 8];
    return {a, b};
  endfunction

  function automatic logic [1599:0] rnd_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom();
    return s;
  endfunction

  function automatic logic [1599:0] mk_state(input logic [511:0] dig,
                                             input int nbytes);
    logic [1599:0] s;
    s = rnd_state();
    for (int j = 0; j < nbytes; j++) s[8*j +: 8] = dig[511-8*j -: 8];
    return s;
  endfunction

  task automatic capture(input logic [1599:0] st, input logic [1:0] id);
    chk("cap_ready", 32'(state_ready), 32'd1);
    state_in    = st;
    ID          = id;
    state_valid = 1'b1;
    @(negedge ACLK);
    state_valid = 1'b0;
    state_in    = rnd_state();
    ID          = ~id;
  endtask

  task automatic collect(input logic [1599:0] st, input int id,
                         input bit rnd, input int glitch,
                         input int stop_after);
    int n;
    int k;
    int cyc;
    n   = plen(id);
    k   = 0;
    cyc = 0;
    while (k < n && k < stop_after && cyc < 500) begin
      TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (glitch >= 0 && cyc == glitch) begin
        state_valid = 1'b1;
        ID          = 2'd0;
        state_in    = rnd_state();
        chk("ready_in_send", 32'(state_ready), 32'd0);
      end else if (glitch >= 0 && cyc == glitch + 1) begin
        state_valid = 1'b0;
      end
      chk("tvalid", 32'(TVALID), 32'd1);
      chk("tdata", 32'(TDATA), 32'(exp_word(st, k)));
      chk("tlast", 32'(TLAST), 32'(k == n - 1));
      chk("tid", 32'(TID), 32'(id));
      if (TREADY) k++;
      cyc++;
      @(negedge ACLK);
    end
    chk("words_sent", 32'(k), 32'(stop_after < n ? stop_after : n));
    if (!rnd && stop_after >= n) chk("pkt_cycles", 32'(cyc), 32'(n));
    if (k == n) begin
      chk("end_tvalid", 32'(TVALID), 32'd0);
      chk("end_ready", 32'(state_ready), 32'd1);
      chk("end_tlast", 32'(TLAST), 32'd0);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", 32'(state_ready), 32'd1);
    chk("rst_tvalid", 32'(TVALID), 32'd0);
    chk("rst_tlast", 32'(TLAST), 32'd0);
    chk("rst_tdata", 32'(TDATA), 32'd0);
    chk("rst_tid", 32'(TID), 32'd0);
  endtask

  initial begin
    logic [1599:0] sa;
    logic [1599:0] sb;
    int id;

    repeat (2) @(negedge ACLK);
    chk_reset_outs();
    ARESET = 1'b0;
    TREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("idle_tready_tvalid", 32'(TVALID), 32'd0);
    chk("idle_tready_ready", 32'(state_ready), 32'd1);

    sa = mk_state(D256, 32);
    capture(sa, 2'd1);
    collect(sa, 1, 1'b0, -1, 99);

    sa = mk_state(D224, 28);
    capture(sa, 2'd0);
    collect(sa, 0, 1'b0, -1, 99);

    sa = mk_state(D512, 64);
    capture(sa, 2'd3);
    collect(sa, 3, 1'b1, -1, 99);

    capture(sa, 2'd3);
    collect(sa, 3, 1'b1, 5, 99);

    sa = mk_state(D256, 32);
    capture(sa, 2'd1);
    collect(sa, 1, 1'b0, -1, 6);
    ARESET      = 1'b1;
    state_valid = 1'b1;
    TREADY      = 1'b1;
    @(negedge ACLK);
    chk_reset_outs();
    ARESET      = 1'b0;
    state_valid = 1'b0;
    sb = rnd_state();
    capture(sb, 2'd1);
    collect(sb, 1, 1'b0, -1, 99);

    sa = rnd_state();
    sb = rnd_state();
    state_in    = sa;
    ID          = 2'd1;
    state_valid = 1'b1;
    @(negedge ACLK);
    state_in = sb;
    ID       = 2'd2;
    collect(sa, 1, 1'b0, -1, 99);
    @(negedge ACLK);
    state_valid = 1'b0;
    collect(sb, 2, 1'b0, -1, 99);

    for (int p = 0; p < 6; p++) begin
      id = $urandom_range(0, 3);
      sa = rnd_state();
      capture(sa, 2'(id));
      collect(sa, id, 1'b1, -1, 99);
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
